// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT245 byte scheduler.
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_TURN   = 3'd1,
        ST_RD_STROBE = 3'd2,
        ST_RD_DONE   = 3'd3,
        ST_WR_SETUP  = 3'd4,
        ST_WR_STROBE = 3'd5,
        ST_WR_DONE   = 3'd6
    } state_t;

    typedef enum logic {
        SRV_WR = 1'b0,
        SRV_RD = 1'b1
    } served_t;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DEF_RD_WAIT = 2;
    localparam int unsigned DEF_WR_WAIT = 2;

endpackage

// File: rtl/ftdi_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module ftdi_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_q1;
    logic r_q2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_q1 <= RST_VAL;
            r_q2 <= RST_VAL;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/ftdi_sched.sv
// FT245 async-FIFO bus scheduler: round-robin between read and write transfers,
// all bus outputs registered from the next state.
module ftdi_sched
    import ftdi_pkg::*;
#(
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxf,
    input  logic       txe,
    output logic       oe,
    output logic       rd,
    output logic       wr,
    inout  logic [7:0] dq,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    logic             w_rxf_s;
    logic             w_txe_s;
    logic             w_rd_pend;
    logic             w_wr_pend;
    logic             w_cap;
    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    served_t          r_last;
    served_t          w_last_d;
    logic             r_oe;
    logic             r_rd;
    logic             r_wr;
    logic             r_dq_en;
    logic [7:0]       r_dq_out;
    logic             r_tx_ack;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;

    ftdi_sync2 #(.RST_VAL(1'b1)) u_sync_rxf (
        .clk   (clk),
        .n_rst (n_rst),
        .i_d   (rxf),
        .o_q   (w_rxf_s)
    );

    ftdi_sync2 #(.RST_VAL(1'b1)) u_sync_txe (
        .clk   (clk),
        .n_rst (n_rst),
        .i_d   (txe),
        .o_q   (w_txe_s)
    );

    assign w_rd_pend = ~w_rxf_s;
    assign w_wr_pend = tx_req & ~w_txe_s;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_last_d  = r_last;
        w_cap     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // On a tie, serve whichever side was not served last.
                if (w_rd_pend && (!w_wr_pend || r_last == SRV_WR)) begin
                    w_state_d = ST_RD_TURN;
                    w_last_d  = SRV_RD;
                end else if (w_wr_pend) begin
                    w_state_d = ST_WR_SETUP;
                    w_last_d  = SRV_WR;
                end
            end
            ST_RD_TURN: begin
                w_state_d = ST_RD_STROBE;
                w_cnt_d   = CNT_W'(RD_WAIT - 1);
            end
            ST_RD_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_d = ST_RD_DONE;
                    w_cap     = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            ST_RD_DONE: begin
                if (w_rxf_s) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_WR_SETUP: begin
                w_state_d = ST_WR_STROBE;
                w_cnt_d   = CNT_W'(WR_WAIT - 1);
            end
            ST_WR_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_d = ST_WR_DONE;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            ST_WR_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= SRV_WR;
            r_oe       <= 1'b1;
            r_rd       <= 1'b1;
            r_wr       <= 1'b1;
            r_dq_en    <= 1'b0;
            r_dq_out   <= 8'h00;
            r_tx_ack   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_last     <= w_last_d;
            r_oe       <= !(w_state_d inside {ST_RD_TURN, ST_RD_STROBE, ST_RD_DONE});
            r_rd       <= (w_state_d != ST_RD_STROBE);
            r_wr       <= (w_state_d != ST_WR_STROBE);
            r_dq_en    <= (w_state_d inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_DONE});
            r_tx_ack   <= (w_state_d == ST_WR_DONE);
            r_rx_valid <= w_cap;
            // Latch the byte once so the bus stays stable even if tx_req/tx_data move.
            if (r_state == ST_IDLE && w_state_d == ST_WR_SETUP) begin
                r_dq_out <= tx_data;
            end
            if (w_cap) begin
                r_rx_data <= dq;
            end
        end
    end

    assign dq       = r_dq_en ? r_dq_out : 8'hzz;
    assign oe       = r_oe;
    assign rd       = r_rd;
    assign wr       = r_wr;
    assign tx_ack   = r_tx_ack;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_ftdi_sched.sv
// Directed bench for ftdi_sched with an FT245-like bus driver on dq.
module tb_ftdi_sched;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxf;
    logic       txe;
    logic       oe;
    logic       rd;
    logic       wr;
    wire  [7:0] dq;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tb_dq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The FIFO side drives the bus only while the FPGA has released it.
    assign dq = oe ? 8'hzz : tb_dq;

    ftdi_sched #(.RD_WAIT(2), .WR_WAIT(2)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxf      (rxf),
        .txe      (txe),
        .oe       (oe),
        .rd       (rd),
        .wr       (wr),
        .dq       (dq),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the bus invariants on every sample.
    task automatic step();
        @(negedge clk);
        check("rd_wr_overlap", 32'(rd | wr), 32'd1);
        check("oe_during_rd", 32'((~rd) & oe), 32'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[4];
        int n_ev;
        int n_rx;
        int n_ack;
        logic prev_rd;
        logic prev_wr;
        logic rxf_pulse;
        logic done;

        n_rst   = 1'b0;
        rxf     = 1'b1;
        txe     = 1'b1;
        tx_req  = 1'b0;
        tx_data = 8'h00;
        tb_dq   = 8'hA5;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_rd", 32'(rd), 32'd1);
        check("rst_wr", 32'(wr), 32'd1);
        check("rst_tx_ack", 32'(tx_ack), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        n_rst = 1'b1;
        steps(2);

        // Single read of 8'hA5
        rxf = 1'b0;
        steps(2);
        check("rd_oe_before", 32'(oe), 32'd1);
        step();
        check("rd_turn_oe", 32'(oe), 32'd0);
        check("rd_turn_rd", 32'(rd), 32'd1);
        step();
        check("rd_strobe1", 32'(rd), 32'd0);
        step();
        check("rd_strobe2", 32'(rd), 32'd0);
        check("rd_no_early_valid", 32'(rx_valid), 32'd0);
        step();
        check("rd_end_rd", 32'(rd), 32'd1);
        check("rd_valid", 32'(rx_valid), 32'd1);
        check("rd_data", 32'(rx_data), 32'hA5);
        step();
        check("rd_valid_pulse", 32'(rx_valid), 32'd0);
        check("rd_done_oe", 32'(oe), 32'd0);
        rxf = 1'b1;
        steps(2);
        check("rd_done_hold_oe", 32'(oe), 32'd0);
        step();
        check("rd_idle_oe", 32'(oe), 32'd1);
        check("rd_data_held", 32'(rx_data), 32'hA5);

        // Single write of 8'h3C
        txe     = 1'b0;
        tx_req  = 1'b1;
        tx_data = 8'h3C;
        steps(2);
        check("wr_idle_wr", 32'(wr), 32'd1);
        step();
        check("wr_setup_dq", 32'(dq), 32'h3C);
        check("wr_setup_wr", 32'(wr), 32'd1);
        check("wr_setup_oe", 32'(oe), 32'd1);
        step();
        check("wr_strobe1", 32'(wr), 32'd0);
        check("wr_strobe1_dq", 32'(dq), 32'h3C);
        step();
        check("wr_strobe2", 32'(wr), 32'd0);
        check("wr_no_early_ack", 32'(tx_ack), 32'd0);
        step();
        check("wr_done_wr", 32'(wr), 32'd1);
        check("wr_hold_dq", 32'(dq), 32'h3C);
        check("wr_ack", 32'(tx_ack), 32'd1);
        tx_req = 1'b0;
        step();
        check("wr_ack_pulse", 32'(tx_ack), 32'd0);
        txe = 1'b1;
        steps(3);

        // Tie: read, write, read, write
        tb_dq     = 8'h5A;
        tx_data   = 8'h81;
        rxf       = 1'b0;
        txe       = 1'b0;
        tx_req    = 1'b1;
        n_ev      = 0;
        n_rx      = 0;
        n_ack     = 0;
        prev_rd   = 1'b1;
        prev_wr   = 1'b1;
        rxf_pulse = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            if (!rd && prev_rd && n_ev < 4) begin seq[n_ev] = 1; n_ev++; end
            if (!wr && prev_wr && n_ev < 4) begin seq[n_ev] = 2; n_ev++; end
            prev_rd = rd;
            prev_wr = wr;
            if (rxf_pulse) begin
                rxf       = 1'b0;
                rxf_pulse = 1'b0;
            end
            if (rx_valid) begin
                check("tie_rx_data", 32'(rx_data), 32'h5A);
                n_rx++;
                rxf = 1'b1;
                rxf_pulse = (n_rx < 2);
            end
            if (tx_ack) begin
                n_ack++;
                if (n_ack == 2) begin
                    tx_req = 1'b0;
                    done   = 1'b1;
                end
            end
        end
        check("tie_finished", 32'(done), 32'd1);
        check("tie_events", 32'(n_ev), 32'd4);
        check("tie_order0", 32'(seq[0]), 32'd1);
        check("tie_order1", 32'(seq[1]), 32'd2);
        check("tie_order2", 32'(seq[2]), 32'd1);
        check("tie_order3", 32'(seq[3]), 32'd2);
        rxf = 1'b1;
        txe = 1'b1;
        steps(4);

        // txe high blocks writes; tx_req dropped mid-transfer still gets an ack
        tx_req  = 1'b1;
        tx_data = 8'hE7;
        for (int i = 0; i < 8; i++) begin
            step();
            check("blk_wr", 32'(wr), 32'd1);
            check("blk_ack", 32'(tx_ack), 32'd0);
        end
        txe = 1'b0;
        steps(2);
        check("blk_rel_wr", 32'(wr), 32'd1);
        step();
        check("blk_setup_dq", 32'(dq), 32'hE7);
        step();
        check("blk_strobe", 32'(wr), 32'd0);
        tx_req = 1'b0;
        step();
        check("blk_strobe2", 32'(wr), 32'd0);
        step();
        check("drop_ack", 32'(tx_ack), 32'd1);
        check("drop_dq", 32'(dq), 32'hE7);
        step();
        check("drop_ack_pulse", 32'(tx_ack), 32'd0);
        txe = 1'b1;
        steps(3);

        // Reset in the middle of a read strobe
        tb_dq = 8'hC3;
        rxf   = 1'b0;
        steps(3);
        check("rr_turn_oe", 32'(oe), 32'd0);
        step();
        check("rr_strobe", 32'(rd), 32'd0);
        #2;
        n_rst = 1'b0;
        #1;
        check("rr_async_rd", 32'(rd), 32'd1);
        check("rr_async_oe", 32'(oe), 32'd1);
        @(negedge clk);
        check("rr_no_valid", 32'(rx_valid), 32'd0);
        check("rr_data_clr", 32'(rx_data), 32'h00);
        n_rst = 1'b1;
        steps(2);
        check("rr_fill_oe", 32'(oe), 32'd1);
        check("rr_fill_valid", 32'(rx_valid), 32'd0);
        step();
        check("rr_first_oe", 32'(oe), 32'd0);
        step();
        check("rr_rd1", 32'(rd), 32'd0);
        step();
        check("rr_rd2", 32'(rd), 32'd0);
        step();
        check("rr_valid", 32'(rx_valid), 32'd1);
        check("rr_data", 32'(rx_data), 32'hC3);
        rxf = 1'b1;
        steps(4);
        check("rr_idle_oe", 32'(oe), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
